// File: rtl/bram0_stream_loader_if.sv
// Stream-in and BRAM0 write-port bundle for bram0_stream_loader.
// The slave modport is the loader's view; master is the feeder/memory side.
interface bram0_stream_loader_if #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 8
);
    logic                     s_valid_i;
    logic [IN_DATA_WIDTH-1:0] s_data_i;
    logic                     s_ready_o;
    logic [AWIDTH-1:0]        addr_b0_o;
    logic                     ce_b0_o;
    logic                     we_b0_o;
    logic [DWIDTH-1:0]        d_b0_o;

    modport master (
        output s_valid_i,
        output s_data_i,
        input  s_ready_o,
        input  addr_b0_o,
        input  ce_b0_o,
        input  we_b0_o,
        input  d_b0_o
    );

    modport slave (
        input  s_valid_i,
        input  s_data_i,
        output s_ready_o,
        output addr_b0_o,
        output ce_b0_o,
        output we_b0_o,
        output d_b0_o
    );
endinterface

// File: rtl/bram0_stream_loader.sv
// Packs a byte stream four lanes per row into BRAM0 from address 0, then
// hands the row count to the accumulate stage with a one-cycle start pulse.
module bram0_stream_loader #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 8,
    parameter int MEM_SIZE      = 256,
    parameter int CNT_BIT       = 31
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load_start_i,
    input  logic [CNT_BIT-1:0]     load_count_i,
    bram0_stream_loader_if.slave   bus,
    input  logic                   acc_idle_i,
    output logic                   start_run_o,
    output logic [CNT_BIT-1:0]     run_count_o,
    output logic                   idle_o,
    output logic                   load_o,
    output logic                   done_o
);

    // Row counters need one extra bit so N == MEM_SIZE is representable.
    localparam int RW = AWIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        KICK = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                       state, state_next;
    logic [RW-1:0]                rows_n;
    logic [RW-1:0]                row_cnt;
    logic [1:0]                   lane_cnt;
    logic                         s_ready;
    logic [3*IN_DATA_WIDTH-1:0]   pack_p0;
    logic                         wr_vld_p1;
    logic [AWIDTH-1:0]            addr_p1;
    logic [DWIDTH-1:0]            d_p1;

    logic                         load_take;
    logic                         accept;
    logic                         row_done;
    logic                         last_accept;

    function automatic logic [RW-1:0] sat_rows(input logic [CNT_BIT-1:0] cnt);
        if (cnt > CNT_BIT'(MEM_SIZE))
            return RW'(MEM_SIZE);
        else
            return cnt[RW-1:0];
    endfunction

    assign load_take   = (state == IDLE) && load_start_i;
    assign accept      = bus.s_valid_i && s_ready;
    assign row_done    = accept && (lane_cnt == 2'd3);
    assign last_accept = row_done && (row_cnt == rows_n - RW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_run_o = 1'b0;
        case (state)
            IDLE: begin
                if (load_start_i)
                    state_next = (load_count_i != '0) ? LOAD : DONE;
            end
            LOAD: begin
                // Leave once the final row's write pulse is on the port.
                if (wr_vld_p1 && (row_cnt == rows_n))
                    state_next = KICK;
            end
            KICK: begin
                if (acc_idle_i) begin
                    start_run_o = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rows_n      <= '0;
            row_cnt     <= '0;
            lane_cnt    <= '0;
            s_ready     <= 1'b0;
            run_count_o <= '0;
        end else if (load_take) begin
            rows_n      <= sat_rows(load_count_i);
            run_count_o <= CNT_BIT'(sat_rows(load_count_i));
            row_cnt     <= '0;
            lane_cnt    <= '0;
            s_ready     <= (load_count_i != '0);
        end else if (accept) begin
            lane_cnt <= lane_cnt + 2'd1;
            if (row_done)
                row_cnt <= row_cnt + RW'(1);
            if (last_accept)
                s_ready <= 1'b0;
        end
    end

    // Stage p0: lanes 0..2 held until the lane-3 element completes the row
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pack_p0 <= '0;
        end else if (accept) begin
            case (lane_cnt)
                2'd0:    pack_p0[0 +: IN_DATA_WIDTH]               <= bus.s_data_i;
                2'd1:    pack_p0[IN_DATA_WIDTH +: IN_DATA_WIDTH]   <= bus.s_data_i;
                2'd2:    pack_p0[2*IN_DATA_WIDTH +: IN_DATA_WIDTH] <= bus.s_data_i;
                default: ;
            endcase
        end
    end

    // Stage p1: single-cycle BRAM0 write; address and data hold afterwards
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_vld_p1 <= 1'b0;
            addr_p1   <= '0;
            d_p1      <= '0;
        end else begin
            wr_vld_p1 <= row_done;
            if (row_done) begin
                addr_p1 <= row_cnt[AWIDTH-1:0];
                d_p1    <= {bus.s_data_i, pack_p0};
            end
        end
    end

    assign bus.s_ready_o = s_ready;
    assign bus.ce_b0_o   = wr_vld_p1;
    assign bus.we_b0_o   = wr_vld_p1;
    assign bus.addr_b0_o = addr_p1;
    assign bus.d_b0_o    = d_p1;

    assign idle_o = (state == IDLE);
    assign load_o = (state == LOAD);
    assign done_o = (state == DONE);

endmodule

// File: tb/tb_bram0_stream_loader.sv
// Directed bench for bram0_stream_loader: write log, start/done pulse counts,
// and immediate-assertion checks against hand-computed values.
module tb_bram0_stream_loader;

    localparam int IN_DATA_WIDTH = 8;
    localparam int DWIDTH        = 32;
    localparam int AWIDTH        = 8;
    localparam int MEM_SIZE      = 256;
    localparam int CNT_BIT       = 31;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               load_start;
    logic [CNT_BIT-1:0] load_count;
    logic               acc_idle;
    logic               start_run;
    logic [CNT_BIT-1:0] run_count;
    logic               idle, load, done;

    int checks = 0;
    int errors = 0;

    int          wr_cnt = 0;
    int          start_cnt = 0;
    int          done_cnt = 0;
    int          pulse_err = 0;
    logic        prev_ce = 1'b0;
    logic [7:0]  log_addr [0:1023];
    logic [31:0] log_data [0:1023];

    bram0_stream_loader_if #(
        .IN_DATA_WIDTH(IN_DATA_WIDTH), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH)
    ) bus ();

    bram0_stream_loader #(
        .IN_DATA_WIDTH(IN_DATA_WIDTH), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH),
        .MEM_SIZE(MEM_SIZE), .CNT_BIT(CNT_BIT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_start_i (load_start),
        .load_count_i (load_count),
        .bus          (bus.slave),
        .acc_idle_i   (acc_idle),
        .start_run_o  (start_run),
        .run_count_o  (run_count),
        .idle_o       (idle),
        .load_o       (load),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    // Observe the write port, start and done once per cycle on the falling edge.
    always @(negedge clk) begin
        if (bus.ce_b0_o || bus.we_b0_o) begin
            if (!(bus.ce_b0_o && bus.we_b0_o) || prev_ce)
                pulse_err++;
            if (wr_cnt < 1024) begin
                log_addr[wr_cnt] = bus.addr_b0_o;
                log_data[wr_cnt] = bus.d_b0_o;
            end
            wr_cnt++;
        end
        prev_ce = bus.ce_b0_o;
        if (start_run) start_cnt++;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int n);
        load_start = 1'b1;
        load_count = CNT_BIT'(n);
        step();
        load_start = 1'b0;
    endtask

    // Offer n elements base, base+1, ...; valid follows pat bit per cycle.
    task automatic send(input int n, input int base, input logic [15:0] pat,
                        input int budget, output int acc);
        int   cyc;
        logic take;
        acc = 0;
        cyc = 0;
        while (acc < n && cyc < budget) begin
            bus.s_valid_i = pat[cyc % 16];
            bus.s_data_i  = 8'(base + acc);
            take = bus.s_valid_i && bus.s_ready_o;
            step();
            if (take) acc++;
            cyc++;
        end
        bus.s_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c = 0;
        while (!idle && c < budget) begin
            step();
            c++;
        end
        chk(tag, idle, 1);
    endtask

    initial begin
        int acc, acc2, wb, sb, db, bad;

        reset_n       = 1'b0;
        load_start    = 1'b0;
        load_count    = '0;
        acc_idle      = 1'b1;
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;
        step();
        step();

        // Reset state
        chk("rst_idle", idle, 1);
        chk("rst_load", load, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", bus.s_ready_o, 0);
        chk("rst_ce", bus.ce_b0_o, 0);
        chk("rst_we", bus.we_b0_o, 0);
        chk("rst_addr", bus.addr_b0_o, 0);
        chk("rst_d", bus.d_b0_o, 0);
        chk("rst_start", start_run, 0);
        chk("rst_count", run_count, 0);
        reset_n = 1'b1;
        step();

        // 1: two rows, continuous valid
        wb = wr_cnt; sb = start_cnt; db = done_cnt;
        pulse_start(2);
        chk("t1_load", load, 1);
        chk("t1_ready", bus.s_ready_o, 1);
        chk("t1_count", run_count, 2);
        send(8, 1, 16'hFFFF, 50, acc);
        chk("t1_acc", acc, 8);
        chk("t1_ready_fall", bus.s_ready_o, 0);
        chk("t1_ce_row1", bus.ce_b0_o, 1);
        chk("t1_addr_row1", bus.addr_b0_o, 1);
        wait_idle("t1_idle", 20);
        chk("t1_writes", wr_cnt - wb, 2);
        chk("t1_a0", log_addr[wb], 0);
        chk("t1_d0", log_data[wb], 32'h04030201);
        chk("t1_a1", log_addr[wb+1], 1);
        chk("t1_d1", log_data[wb+1], 32'h08070605);
        chk("t1_starts", start_cnt - sb, 1);
        chk("t1_dones", done_cnt - db, 1);
        chk("t1_count_hold", run_count, 2);

        // 2: same data with gaps in valid
        wb = wr_cnt; sb = start_cnt;
        pulse_start(2);
        send(8, 1, 16'b1001_0011_0100_1001, 80, acc);
        chk("t2_acc", acc, 8);
        chk("t2_ready_fall", bus.s_ready_o, 0);
        wait_idle("t2_idle", 20);
        chk("t2_writes", wr_cnt - wb, 2);
        chk("t2_d0", log_data[wb], 32'h04030201);
        chk("t2_d1", log_data[wb+1], 32'h08070605);
        chk("t2_a1", log_addr[wb+1], 1);
        chk("t2_starts", start_cnt - sb, 1);

        // 3: zero count goes straight to DONE
        wb = wr_cnt; sb = start_cnt;
        pulse_start(0);
        chk("t3_done", done, 1);
        chk("t3_count", run_count, 0);
        chk("t3_ready", bus.s_ready_o, 0);
        step();
        chk("t3_idle", idle, 1);
        chk("t3_writes", wr_cnt - wb, 0);
        chk("t3_starts", start_cnt - sb, 0);

        // 4: accumulate stage busy holds the loader in KICK
        wb = wr_cnt; sb = start_cnt;
        acc_idle = 1'b0;
        pulse_start(1);
        send(4, 8'h10, 16'hFFFF, 20, acc);
        chk("t4_ce", bus.ce_b0_o, 1);
        chk("t4_d", bus.d_b0_o, 32'h13121110);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (idle || load || done || start_run) bad++;
        end
        chk("t4_kick_hold", bad, 0);
        acc_idle = 1'b1;
        #1;
        chk("t4_start", start_run, 1);
        step();
        chk("t4_done", done, 1);
        chk("t4_start_once", start_run, 0);
        step();
        chk("t4_idle", idle, 1);
        chk("t4_starts", start_cnt - sb, 1);
        chk("t4_writes", wr_cnt - wb, 1);

        // 5: oversize count saturates to MEM_SIZE rows; mid-load start ignored
        wb = wr_cnt; sb = start_cnt; db = done_cnt;
        pulse_start(300);
        chk("t5_count", run_count, 256);
        send(400, 0, 16'hFFFF, 500, acc);
        pulse_start(5);
        chk("t5_still_load", load, 1);
        chk("t5_count_kept", run_count, 256);
        send(800, 400, 16'hFFFF, 700, acc2);
        chk("t5_acc_total", acc + acc2, 1024);
        chk("t5_ready", bus.s_ready_o, 0);
        wait_idle("t5_idle", 20);
        chk("t5_writes", wr_cnt - wb, 256);
        bad = 0;
        for (int k = 0; k < 256; k++)
            if (log_addr[wb+k] !== 8'(k)) bad++;
        chk("t5_addr_seq", bad, 0);
        chk("t5_d0", log_data[wb], 32'h03020100);
        chk("t5_d100", log_data[wb+100], 32'h93929190);
        chk("t5_d255", log_data[wb+255], 32'hFFFEFDFC);
        chk("t5_starts", start_cnt - sb, 1);
        chk("t5_dones", done_cnt - db, 1);
        chk("t5_count_end", run_count, 256);

        // 6: reset in the middle of row 1
        wb = wr_cnt; sb = start_cnt;
        pulse_start(2);
        send(6, 8'h21, 16'hFFFF, 20, acc);
        reset_n = 1'b0;
        #1;
        chk("t6_idle", idle, 1);
        chk("t6_load", load, 0);
        chk("t6_ready", bus.s_ready_o, 0);
        chk("t6_ce", bus.ce_b0_o, 0);
        chk("t6_addr", bus.addr_b0_o, 0);
        chk("t6_d", bus.d_b0_o, 0);
        chk("t6_count", run_count, 0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("t6_writes", wr_cnt - wb, 1);
        chk("t6_no_start", start_cnt - sb, 0);
        wb = wr_cnt;
        pulse_start(1);
        send(4, 8'hA0, 16'hFFFF, 20, acc);
        wait_idle("t6_idle_after", 20);
        chk("t6_new_writes", wr_cnt - wb, 1);
        chk("t6_new_a", log_addr[wb], 0);
        chk("t6_new_d", log_data[wb], 32'hA3A2A1A0);
        chk("t6_new_start", start_cnt - sb, 1);

        chk("pulse_shape", pulse_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram0_stream_loader.md
Name: bram0_stream_loader

Overview:
Upstream feeder for the BRAM accumulate stage. It accepts a byte stream over a valid/ready handshake and packs four bytes into each 32-bit row. It writes those rows to BRAM0 at consecutive addresses starting at 0. When the requested number of rows is written, it issues a one-cycle start pulse and a row count to the accumulate stage, waiting first until that stage is idle.

Parameters:
IN_DATA_WIDTH, 8, width of one stream element / one packed lane
DWIDTH, 32, BRAM0 row width; fixed at 4*IN_DATA_WIDTH
AWIDTH, 8, BRAM0 address width
MEM_SIZE, 256, BRAM0 depth in rows (2**AWIDTH)
CNT_BIT, 31, width of row-count inputs/outputs

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
load_start_i  in  1  start a load; sampled only in IDLE
load_count_i  in  CNT_BIT  number of rows to load; sampled with load_start_i
s_valid_i  in  1  stream element valid
s_data_i  in  IN_DATA_WIDTH  stream element
s_ready_o  out  1  loader accepts element this cycle
acc_idle_i  in  1  accumulate stage is in IDLE
start_run_o  out  1  one-cycle start pulse to accumulate stage
run_count_o  out  CNT_BIT  row count for accumulate stage
addr_b0_o  out  AWIDTH  BRAM0 address
ce_b0_o  out  1  BRAM0 chip enable
we_b0_o  out  1  BRAM0 write enable
d_b0_o  out  DWIDTH  BRAM0 write data
idle_o  out  1  FSM in IDLE
load_o  out  1  FSM in LOAD
done_o  out  1  FSM in DONE

Behaviour:
- Reset, asynchronous: FSM=IDLE and all counters and pack register cleared. Every output is 0 except idle_o=1.
- FSM states: IDLE, LOAD, KICK, DONE. Exactly one of idle_o, load_o and done_o is 1 in IDLE, LOAD and DONE respectively. All three are 0 in KICK.
- IDLE to LOAD: on load_start_i=1 with load_count_i != 0.
  - Captured count N = min(load_count_i, MEM_SIZE).
  - run_count_o <= N.
  - Row counter and lane counter <= 0.
- IDLE to DONE: on load_start_i=1 with load_count_i=0. No BRAM write and no start_run_o; run_count_o <= 0.
- load_start_i is ignored in LOAD, KICK and DONE.
- s_ready_o is registered. It is 1 in LOAD while fewer than 4*N elements have been accepted. It falls in the cycle after the 4*N-th element is accepted, and is 0 in every other state.
- Handshake: an element is accepted when s_valid_i & s_ready_o at a rising edge. s_data_i is ignored otherwise. Gaps in s_valid_i are allowed, and there is no limit on gap length.
- Packing: lane counter 0..3. The element accepted at lane k goes to pack bits [(k+1)*IN_DATA_WIDTH-1 : k*IN_DATA_WIDTH], so the first element sits in the LSB lane.
- Write pulse: the cycle after the lane-3 element is accepted:
  - ce_b0_o=1, we_b0_o=1, addr_b0_o = row counter, d_b0_o = completed row.
  - The row counter increments after the write.
  - The pulse lasts 1 cycle. In all other cycles ce_b0_o=we_b0_o=0, and addr_b0_o and d_b0_o hold their last values.
- The write pulse and the next lane-0 acceptance may occur in the same cycle; no element is lost.
- LOAD to KICK: in the cycle of the write of row N-1.
- Row addresses stay within 0..N-1 ≤ MEM_SIZE-1; no wrap occurs.
- KICK: waits while acc_idle_i=0. When acc_idle_i=1, start_run_o=1 for exactly one cycle, then the FSM goes to DONE.
- DONE: lasts 1 cycle, then IDLE.
- run_count_o holds its value from capture until the next accepted load_start_i or reset.
- Reset mid-operation: the load is abandoned and any partial row is discarded with no write. start_run_o is not issued.

Test Plan:
1. load_count_i=2, stream 0x01..0x08 with continuous valid. Required response:
   - addr 0 written with 0x04030201 and addr 1 with 0x08070605, each as a single-cycle ce/we pulse.
   - start_run_o pulses once with run_count_o=2, then done_o for 1 cycle, then idle_o=1.
2. Same data with s_valid_i toggled 1-0-0-1 randomly. Required response: identical BRAM contents; s_ready_o falls one cycle after the 8th acceptance.
3. load_count_i=0. Required response: IDLE to DONE to IDLE, no ce_b0_o pulse, no start_run_o, run_count_o=0.
4. load_count_i=1 with acc_idle_i held 0 for 10 cycles after the write. Required response:
   - The FSM remains in KICK with start_run_o=0.
   - start_run_o pulses on the first cycle acc_idle_i=1.
5. load_count_i=300, stream 1200 elements. Required response:
   - Exactly 256 writes, to addr 0..255; run_count_o=256.
   - s_ready_o=0 after 1024 acceptances.
   - load_start_i pulsed mid-load has no effect.
6. reset_n asserted after 6 of 8 elements. Required response: all outputs 0 except idle_o=1; no write for row 1, no start_run_o. A new load of count 1 then writes addr 0 correctly.
